board_move_sched: RTL

Owns the 8x8 chess board state that feeds the VGA pixel pipeline and schedules every change to it. Game logic submits moves over a valid/ready handshake into a small FIFO. The block commits queued moves to the board only while the display is in vertical sync, so a frame never shows a half-applied move. Its board output drives the VGA top's `boardPos` array directly.

---
 rtl/board_move_sched.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/board_move_sched.sv
// board_move_sched: owns the 8x8 chess board shown by the VGA pipeline.
// Moves arrive over a valid/ready handshake into a small FIFO. They are
// committed only while the display is in vertical blank, so a frame never
// shows a half-applied move.
// Optional feature macro: BOARD_SCHED_PROMO_EN. When it is defined, a pawn
// reaching the far rank is written as a queen of the same colour.
module board_move_sched #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          vsync_n,
    input  logic                          new_game,
    input  logic                          move_valid,
    output logic                          move_ready,
    input  logic [5:0]                    move_from,
    input  logic [5:0]                    move_to,
    output logic [7:0][7:0][4:0]          board,
    output logic                          applied,
    output logic                          captured,
    output logic                          move_err,
    output logic [$clog2(FIFO_DEPTH):0]   pending
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WRITE,
        CLEAR
    } state_t;

    // Piece type of the back rank, column by column: R N B Q K B N R.
    function automatic logic [2:0] backRankType(input int col);
        logic [2:0] pieceType;
        case (col)
            0, 7:    pieceType = 3'd4;
            1, 6:    pieceType = 3'd2;
            2, 5:    pieceType = 3'd3;
            3:       pieceType = 3'd5;
            default: pieceType = 3'd6;
        endcase
        return pieceType;
    endfunction

    // Standard starting position; black occupies rows 0-1, white rows 6-7.
    function automatic logic [7:0][7:0][4:0] initialBoard();
        logic [7:0][7:0][4:0] b;
        b = '0;
        for (int c = 0; c < 8; c++) begin
            b[0][c] = {backRankType(c), 1'b1, 1'b0};
            b[1][c] = 5'h06;
            b[6][c] = 5'h04;
            b[7][c] = {backRankType(c), 1'b0, 1'b0};
        end
        return b;
    endfunction

    localparam logic [7:0][7:0][4:0] INIT_BOARD = initialBoard();

    state_t                state_q, state_d;
    logic [7:0][7:0][4:0]  board_q, board_d;
    logic                  vsyncMeta_q, vsyncSync_q;
    logic [11:0]           fifoMem_q [FIFO_DEPTH];
    logic [AW-1:0]         wrPtr_q, wrPtr_d;
    logic [AW-1:0]         rdPtr_q, rdPtr_d;
    logic [AW:0]           count_q, count_d;
    logic [5:0]            curFrom_q, curFrom_d;
    logic [5:0]            curTo_q, curTo_d;
    logic                  capFlag_q, capFlag_d;
    logic                  applied_q, applied_d;
    logic                  captured_q, captured_d;
    logic                  moveErr_q, moveErr_d;

    logic                  vblank;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  queueNonEmpty;
    logic [11:0]           headEntry;
    logic [5:0]            headFrom;
    logic [5:0]            headTo;
    logic [2:0]            headSrcType;
    logic [4:0]            movedSq;

    assign vblank        = !vsyncSync_q;
    assign full          = (count_q == (AW+1)'(FIFO_DEPTH));
    assign queueNonEmpty = (count_q != '0);
    assign move_ready    = !full;
    assign push          = move_valid && move_ready && !new_game;
    assign pop           = (state_q == CHECK);
    assign headEntry     = fifoMem_q[rdPtr_q];
    assign headFrom      = headEntry[11:6];
    assign headTo        = headEntry[5:0];
    assign headSrcType   = board_q[headFrom[5:3]][headFrom[2:0]][4:2];

    // Bring the vgaclk-domain vsync into the clk domain; idle level is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsyncMeta_q <= 1'b1;
            vsyncSync_q <= 1'b1;
        end else begin
            vsyncMeta_q <= vsync_n;
            vsyncSync_q <= vsyncMeta_q;
        end
    end

    // Move storage; contents need no reset because occupancy guards reads.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= {move_from, move_to};
        end
    end

    // Queue pointers and occupancy; new_game flushes everything queued.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (new_game) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wrPtr_d = wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Square written to the destination: the moving piece, now marked moved.
    always_comb begin
        movedSq = {board_q[curFrom_q[5:3]][curFrom_q[2:0]][4:1], 1'b1};
`ifdef BOARD_SCHED_PROMO_EN
        if (board_q[curFrom_q[5:3]][curFrom_q[2:0]][4:2] == 3'd1) begin
            if (!board_q[curFrom_q[5:3]][curFrom_q[2:0]][1] && (curTo_q[5:3] == 3'd0)) begin
                movedSq = 5'h15;
            end else if (board_q[curFrom_q[5:3]][curFrom_q[2:0]][1] && (curTo_q[5:3] == 3'd7)) begin
                movedSq = 5'h17;
            end
        end
`endif
    end

    // Commit sequencer: check the head move, write destination, clear source.
    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        curFrom_d  = curFrom_q;
        curTo_d    = curTo_q;
        capFlag_d  = capFlag_q;
        applied_d  = 1'b0;
        captured_d = 1'b0;
        moveErr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (queueNonEmpty && vblank) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                curFrom_d = headFrom;
                curTo_d   = headTo;
                if ((headSrcType == 3'd0) || (headFrom == headTo)) begin
                    moveErr_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                capFlag_d = (board_q[curTo_q[5:3]][curTo_q[2:0]][4:2] != 3'd0);
                board_d[curTo_q[5:3]][curTo_q[2:0]] = movedSq;
                state_d = CLEAR;
            end
            CLEAR: begin
                board_d[curFrom_q[5:3]][curFrom_q[2:0]] = 5'h00;
                applied_d  = 1'b1;
                captured_d = capFlag_q;
                state_d    = (queueNonEmpty && vblank) ? CHECK : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (new_game) begin
            state_d    = IDLE;
            board_d    = INIT_BOARD;
            applied_d  = 1'b0;
            captured_d = 1'b0;
            moveErr_d  = 1'b0;
        end
    end

    // State, board and pulse registers; reset restores the starting position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            board_q    <= INIT_BOARD;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            curFrom_q  <= '0;
            curTo_q    <= '0;
            capFlag_q  <= 1'b0;
            applied_q  <= 1'b0;
            captured_q <= 1'b0;
            moveErr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            board_q    <= board_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            curFrom_q  <= curFrom_d;
            curTo_q    <= curTo_d;
            capFlag_q  <= capFlag_d;
            applied_q  <= applied_d;
            captured_q <= captured_d;
            moveErr_q  <= moveErr_d;
        end
    end

    assign board    = board_q;
    assign applied  = applied_q;
    assign captured = captured_q;
    assign move_err = moveErr_q;
    assign pending  = count_q;

endmodule
